// File: rtl/uart_receiver.sv
// UART receive path: 2-flop synchroniser, 16x-oversampled start/data/parity/stop
// deserialiser with even parity check, one-cycle valid pulse and sticky error flags.
module uart_receiver #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Rx_EN,
  input  logic                 Rx_sample_ENABLE,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] Rx_DATA,
  output logic                 Rx_VALID,
  output logic                 Rx_PERROR,
  output logic                 Rx_FERROR
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_flag_q, perr_flag_d;
  logic                 ferr_flag_q, ferr_flag_d;

  logic                 rxd_s;
  logic                 tick_end;
  logic [DATA_BITS:0]   shift_ext;

  assign rxd_s     = sync_q[1];
  assign tick_end  = (tick_q == TICK_END);
  assign shift_ext = {rxd_s, shift_q};

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], RxD};
    tick_d      = tick_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    perr_flag_d = perr_flag_q;
    ferr_flag_d = ferr_flag_q;

    if (!Rx_EN) begin
      state_d   = IDLE;
      tick_d    = '0;
      bit_cnt_d = '0;
    end else if (Rx_sample_ENABLE) begin
      unique case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d     = START;
            tick_d      = '0;
            perr_flag_d = 1'b0;
            ferr_flag_d = 1'b0;
          end
        end
        START: begin
          // mid start bit: a high line here means a glitch, not a frame
          if (tick_q == TICK_MID) begin
            tick_d    = '0;
            bit_cnt_d = '0;
            state_d   = rxd_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_end) begin
            tick_d  = '0;
            shift_d = shift_ext[DATA_BITS:1];
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              state_d   = PARITY;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        PARITY: begin
          if (tick_end) begin
            tick_d  = '0;
            perr_d  = (^shift_q) ^ rxd_s;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        STOP: begin
          // leave half a stop bit early so back-to-back frames are caught
          if (tick_end) begin
            tick_d      = '0;
            state_d     = IDLE;
            perr_flag_d = perr_q;
            ferr_flag_d = ~rxd_s;
            if (!perr_q && rxd_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tick_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      tick_q      <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_flag_q <= 1'b0;
      ferr_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      tick_q      <= tick_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      perr_q      <= perr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_flag_q <= perr_flag_d;
      ferr_flag_q <= ferr_flag_d;
    end
  end

  assign Rx_DATA   = data_q;
  assign Rx_VALID  = valid_q;
  assign Rx_PERROR = perr_flag_q;
  assign Rx_FERROR = ferr_flag_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: serial frames driven bit by bit, expected bytes
// queued by a frame-level model and matched by an independent monitor.
module tb_uart_receiver;

  localparam int DB     = 8;
  localparam int OS     = 16;
  localparam int DIV    = 4;
  localparam int BITCLK = OS * DIV;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          Rx_EN = 1'b0;
  logic          strobe = 1'b0;
  logic          RxD = 1'b1;
  logic [DB-1:0] Rx_DATA;
  logic          Rx_VALID;
  logic          Rx_PERROR;
  logic          Rx_FERROR;

  int            total = 0;
  int            bad = 0;
  bit            strobe_on = 1'b0;
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] last_good = '0;
  logic [DB-1:0] mon_e;

  uart_receiver #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .Rx_EN           (Rx_EN),
    .Rx_sample_ENABLE(strobe),
    .RxD             (RxD),
    .Rx_DATA         (Rx_DATA),
    .Rx_VALID        (Rx_VALID),
    .Rx_PERROR       (Rx_PERROR),
    .Rx_FERROR       (Rx_FERROR)
  );

  always #5 clk = ~clk;

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      c++;
      strobe = strobe_on && (c % DIV == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // monitor: every valid pulse must match the oldest expected byte
  initial begin
    forever begin
      @(negedge clk);
      if (Rx_VALID === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got data %0h want no pulse",
                   Rx_DATA);
        end else begin
          mon_e = exp_q.pop_front();
          chk("valid_data", 32'(Rx_DATA), 32'(mon_e));
          chk("valid_flags", {30'd0, Rx_PERROR, Rx_FERROR}, 32'd0);
        end
        @(negedge clk);
        chk("valid_width", {31'd0, Rx_VALID}, 32'd0);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  function automatic logic [10:0] mk(input logic [7:0] d, input logic p,
                                     input logic s);
    return {s, p, d, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic s, input int gap);
    logic [10:0] f;
    logic        pe;
    logic        fe;
    logic        sp;
    logic        sf;
    f  = mk(d, p, s);
    pe = (^d) ^ p;
    fe = ~s;
    sp = 1'b0;
    sf = 1'b0;
    if (!pe && !fe) exp_q.push_back(d);
    for (int j = 0; j < 11; j++) begin
      RxD = f[j];
      for (int k = 0; k < BITCLK; k++) begin
        @(negedge clk);
        if (j == 10) begin
          sp = sp | Rx_PERROR;
          sf = sf | Rx_FERROR;
        end
      end
      if (j == 0)
        chk("start_clears_flags", {30'd0, Rx_PERROR, Rx_FERROR}, 32'd0);
    end
    if (!pe && !fe) last_good = d;
    chk("perr_flag", {31'd0, sp}, {31'd0, pe});
    chk("ferr_flag", {31'd0, sf}, {31'd0, fe});
    chk("data_hold", 32'(Rx_DATA), 32'(last_good));
    RxD = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    logic [10:0] f;
    logic [7:0]  d;
    logic        s;
    logic        p;
    int          gap;

    repeat (3) @(negedge clk);
    chk("rst_data", 32'(Rx_DATA), 32'd0);
    chk("rst_valid", {31'd0, Rx_VALID}, 32'd0);
    chk("rst_perr", {31'd0, Rx_PERROR}, 32'd0);
    chk("rst_ferr", {31'd0, Rx_FERROR}, 32'd0);
    reset     = 1'b1;
    Rx_EN     = 1'b1;
    strobe_on = 1'b1;
    repeat (BITCLK) @(negedge clk);

    send_frame(8'h55, 1'b0, 1'b1, BITCLK);
    send_frame(8'hA3, 1'b1, 1'b1, BITCLK);
    send_frame(8'h0F, 1'b0, 1'b0, BITCLK);
    send_frame(8'h81, 1'b0, 1'b1, BITCLK);

    // short low glitch must be rejected at the mid start-bit check
    RxD = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    RxD = 1'b1;
    repeat (2 * BITCLK) @(negedge clk);
    chk("glitch_data", 32'(Rx_DATA), 32'(last_good));
    chk("glitch_flags", {30'd0, Rx_PERROR, Rx_FERROR}, 32'd0);

    f = mk(8'hC6, ^8'hC6, 1'b1);
    for (int j = 0; j < 5; j++) begin
      RxD = f[j];
      repeat (BITCLK) @(negedge clk);
    end
    Rx_EN = 1'b0;
    RxD   = 1'b1;
    repeat (3 * BITCLK) @(negedge clk);
    chk("dis_data", 32'(Rx_DATA), 32'(last_good));
    chk("dis_flags", {30'd0, Rx_PERROR, Rx_FERROR}, 32'd0);
    Rx_EN = 1'b1;
    repeat (BITCLK) @(negedge clk);
    send_frame(8'hC6, ^8'hC6, 1'b1, BITCLK);

    f = mk(8'h99, 1'b0, 1'b1);
    for (int j = 0; j < 3; j++) begin
      RxD = f[j];
      repeat (BITCLK) @(negedge clk);
    end
    RxD = f[3];
    repeat (BITCLK / 2) @(negedge clk);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_data", 32'(Rx_DATA), 32'd0);
    chk("async_rst_valid", {31'd0, Rx_VALID}, 32'd0);
    chk("async_rst_flags", {30'd0, Rx_PERROR, Rx_FERROR}, 32'd0);
    last_good = '0;
    RxD = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (BITCLK) @(negedge clk);
    send_frame(8'h3C, ^8'h3C, 1'b1, 0);
    send_frame(8'hE1, ^8'hE1, 1'b1, BITCLK);

    for (int i = 0; i < 12; i++) begin
      d   = 8'($urandom);
      p   = (^d) ^ ($urandom_range(0, 3) == 0);
      s   = ($urandom_range(0, 3) != 0);
      gap = s ? $urandom_range(0, BITCLK)
              : BITCLK + $urandom_range(0, BITCLK);
      send_frame(d, p, s, gap);
    end

    repeat (2 * BITCLK) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver. It is the receive end of the link whose bit timing comes from the team's baud controller.
- Consumes the baud controller's 16x-oversampling strobe as `Rx_sample_ENABLE` and deserialises frames on `RxD`.
- Frame format: 1 start bit (0), DATA_BITS data bits LSB first, 1 even-parity bit, 1 stop bit (1).
- Delivers the byte with a one-cycle valid pulse plus sticky error flags to the host logic.

Parameters:
- DATA_BITS, 8, number of data bits per frame.
- OVERSAMPLE, 16, `Rx_sample_ENABLE` strobes per bit period; must be even and at least 4.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- Rx_EN  in  1  receiver enable; 0 forces the FSM to IDLE.
- Rx_sample_ENABLE  in  1  single-cycle oversampling strobe from the baud controller.
- RxD  in  1  asynchronous serial line, idle high.
- Rx_DATA  out  DATA_BITS  last correctly received byte.
- Rx_VALID  out  1  one-clock pulse: Rx_DATA has just been updated.
- Rx_PERROR  out  1  parity error on the last completed frame.
- Rx_FERROR  out  1  framing error (stop bit 0) on the last completed frame.

Behaviour:
- Reset (reset=0, asynchronous), all registers cleared:
  - State IDLE.
  - Rx_DATA=0, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0.
  - Tick counter, bit counter and shift register = 0.
  - Synchroniser flops = 1.
  - Reset mid-frame discards the frame with no output activity.
- RxD passes through a 2-flop synchroniser. All decisions use the synchronised value, which adds 2 cycles of latency.
- Tick counter: width ceil(log2(OVERSAMPLE)). It advances only in cycles where Rx_sample_ENABLE=1. Cycles without a strobe hold all state.
- IDLE:
  - On a strobe with Rx_EN=1 and RxD_sync=0: go to START, tick=0.
  - Rx_PERROR and Rx_FERROR clear in that same cycle.
- START:
  - Count strobes.
  - At tick = OVERSAMPLE/2-1 (mid start bit), re-check the line.
  - If RxD_sync=1, the start is false: return to IDLE with no flags set.
  - Else tick=0, go to DATA. All later samples are therefore at bit centres.
- DATA:
  - At tick = OVERSAMPLE-1, shift RxD_sync into the MSB of the shift register (right shift, so LSB-first arrival ends LSB-aligned).
  - bit_cnt++ and tick=0.
  - After DATA_BITS samples, go to PARITY.
- PARITY: at tick = OVERSAMPLE-1, capture the parity bit and set perr = (XOR of data bits) XOR sampled bit. Go to STOP.
- STOP, at tick = OVERSAMPLE-1, sample the stop bit. In the next clock:
  - Rx_PERROR <= perr.
  - Rx_FERROR <= (stop==0).
  - If neither error is set: Rx_DATA <= shift register and Rx_VALID=1 for exactly one clock.
  - If either error is set: Rx_DATA holds its previous value and Rx_VALID stays 0.
  - Return to IDLE.
  - A new start edge is recognised on the first strobe after returning to IDLE.
- Rx_EN=0 in any state: next clock goes to IDLE and counters clear. Rx_DATA and error flags hold; no Rx_VALID.
- Error flags are sticky from frame end until the next start detection or reset.
- RxD held low forever (break condition): every frame gets FERROR=1 and PERROR is evaluated normally. After the stop-sample frame end, IDLE re-detects start immediately.
- Rx_sample_ENABLE asserted on consecutive cycles: each cycle counts as one tick. The block never assumes a minimum spacing.
- Latency from the stop-bit sampling strobe to the Rx_VALID rise: 1 clock.
- Full frame length: (DATA_BITS+3)·OVERSAMPLE strobes minus half a bit. The receiver is back in IDLE about half a stop bit early, which allows back-to-back frames.

Test Plan:
- Default parameters, Rx_EN=1, strobe every 4 clocks; send 0x55 with parity 0 and stop 1 -> Rx_VALID pulses once, 1 clock wide, Rx_DATA=0x55, both error flags 0.
- Send 0xA3 with parity bit forced to 1 (correct value is 0) -> Rx_PERROR=1, Rx_FERROR=0, Rx_VALID never rises, Rx_DATA keeps 0x55.
- Send 0x0F with stop bit 0 -> Rx_FERROR=1, no Rx_VALID. Then a clean 0x81 -> the flags clear at its start detection, Rx_VALID pulses, Rx_DATA=0x81.
- RxD low glitch of 3 strobes then high -> no state change beyond START, no Rx_VALID, flags unchanged.
- Deassert Rx_EN after 4 data bits of 0xC6 -> FSM returns to IDLE, no outputs change. Re-enable and send 0xC6 -> Rx_DATA=0xC6.
- Pull reset to 0 mid-DATA, asynchronously between clock edges -> outputs go to 0 immediately. After release, 0x3C back-to-back with 0xE1 -> two Rx_VALID pulses, Rx_DATA = 0x3C then 0xE1.
